fp_add_sequencer: RTL

- Multi-cycle sequencer for IEEE-754 single-precision add/subtract.
- Drives the datapath one operation at a time: unpack, exponent compare, iterative mantissa align, add/sub, iterative normalize, round-to-nearest-even, pack.
- Valid/ready handshake on both sides. It sits between the instruction issue logic and the FPU result writeback.
- Replaces the combinational stage chain with a bounded-latency FSM.

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_round_pack.sv | 44 ++++
 rtl/fp_add_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the multi-cycle IEEE-754 single-precision adder.
package fp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MENT_WIDTH = 23;
    localparam int DEF_EXPO_WIDTH = 8;
    localparam int BIAS           = 2 ** (DEF_EXPO_WIDTH - 1) - 1;
    localparam int WM_WIDTH       = DEF_MENT_WIDTH + 5;

    localparam logic [DEF_DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [DEF_DATA_WIDTH-1:0] INF  = 32'h7F80_0000;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a normalised working mantissa, overflow detection and packing.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MENT_WIDTH = DEF_MENT_WIDTH,
    parameter int EXPO_WIDTH = DEF_EXPO_WIDTH
) (
    input  logic                    sign,
    input  logic [EXPO_WIDTH+1:0]   expo,
    input  logic [MENT_WIDTH+3:0]   mant,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [3:0]              flags
);

    localparam logic [EXPO_WIDTH-1:0] EXP_ONES = '1;

    logic                  lsb, guard, round_bit, sticky, inc, ovf;
    logic [MENT_WIDTH+1:0] rounded;
    logic [MENT_WIDTH-1:0] frac;
    logic [EXPO_WIDTH+1:0] exp_r;

    assign lsb       = mant[3];
    assign guard     = mant[2];
    assign round_bit = mant[1];
    assign sticky    = mant[0];
    assign inc       = guard & (round_bit | sticky | lsb);
    assign rounded   = {1'b0, mant[MENT_WIDTH+3:3]} + {{(MENT_WIDTH+1){1'b0}}, inc};
    assign ovf       = rounded[MENT_WIDTH+1];
    assign frac      = ovf ? rounded[MENT_WIDTH:1] : rounded[MENT_WIDTH-1:0];
    assign exp_r     = expo + {{(EXPO_WIDTH+1){1'b0}}, ovf};

    always_comb begin
        flags               = '0;
        flags[FLAG_INEXACT] = guard | round_bit | sticky;
        result              = {sign, exp_r[EXPO_WIDTH-1:0], frac};
        if (exp_r >= {2'b00, EXP_ONES}) begin
            result               = {sign, EXP_ONES, {MENT_WIDTH{1'b0}}};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Bounded-latency FSM sequencing unpack, align, add, normalise, round and pack for FP add/sub.
module fp_add_sequencer
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MENT_WIDTH = DEF_MENT_WIDTH,
    parameter int EXPO_WIDTH = DEF_EXPO_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic [DATA_WIDTH-1:0] floating1_in,
    input  logic [DATA_WIDTH-1:0] floating2_in,
    input  logic                  opcode_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [DATA_WIDTH-1:0] floating_addition_out,
    output logic [3:0]            flags_out,
    output logic                  busy_out
);

    localparam int WM = MENT_WIDTH + 5;
    localparam int EI = EXPO_WIDTH + 2;
    localparam logic [EXPO_WIDTH-1:0] EXP_ONES    = '1;
    localparam logic [EXPO_WIDTH-1:0] ALIGN_LIMIT = EXPO_WIDTH'(WM - 1);
    localparam logic [EI-1:0]         EXP_MIN     = EI'(1);
    localparam logic [DATA_WIDTH-1:0] NAN_RES     = {1'b0, EXP_ONES, 1'b1, {(MENT_WIDTH-1){1'b0}}};

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] a_q, b_q, result_q, rp_result;
    logic                  op_q, sign_q, sub_q, special_q;
    logic [EI-1:0]         exp_q;
    logic [WM-1:0]         big_q, small_q, sum_w, norm_right, norm_left;
    logic [EXPO_WIDTH-1:0] cnt_q, exp_a, exp_b, diff;
    logic [3:0]            flags_q, rp_flags, spec_flags;
    logic [DATA_WIDTH-1:0] spec_res;
    logic                  sign_a, sign_b, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                  is_special, a_big, sum_zero;
    logic [WM-1:0]         man_a, man_b;

    assign sign_a = a_q[DATA_WIDTH-1];
    assign sign_b = b_q[DATA_WIDTH-1] ^ op_q;
    assign exp_a  = a_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign exp_b  = b_q[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign a_inf  = (exp_a == EXP_ONES) && (a_q[MENT_WIDTH-1:0] == '0);
    assign b_inf  = (exp_b == EXP_ONES) && (b_q[MENT_WIDTH-1:0] == '0);
    assign a_nan  = (exp_a == EXP_ONES) && (a_q[MENT_WIDTH-1:0] != '0);
    assign b_nan  = (exp_b == EXP_ONES) && (b_q[MENT_WIDTH-1:0] != '0);
    assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    // Working mantissa: {carry, hidden, fraction, guard, round, sticky}.
    assign man_a = {2'b01, a_q[MENT_WIDTH-1:0], 3'b000};
    assign man_b = {2'b01, b_q[MENT_WIDTH-1:0], 3'b000};
    assign a_big = a_q[DATA_WIDTH-2:0] >= b_q[DATA_WIDTH-2:0];
    assign diff  = a_big ? exp_a - exp_b : exp_b - exp_a;

    assign sum_w      = sub_q ? big_q - small_q : big_q + small_q;
    assign sum_zero   = (sum_w == '0);
    assign norm_right = {1'b0, big_q[WM-1:2], big_q[1] | big_q[0]};
    assign norm_left  = big_q << 1;

    always_comb begin
        spec_flags = '0;
        spec_res   = a_q;
        if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b))) begin
            spec_res                 = NAN_RES;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign_a, EXP_ONES, {MENT_WIDTH{1'b0}}};
        end else if (b_inf) begin
            spec_res = {sign_b, EXP_ONES, {MENT_WIDTH{1'b0}}};
        end else if (a_zero && b_zero) begin
            spec_res = {sign_a & sign_b, {(DATA_WIDTH-1){1'b0}}};
        end else if (a_zero) begin
            spec_res = {sign_b, b_q[DATA_WIDTH-2:0]};
        end
    end

    fp_round_pack #(
        .DATA_WIDTH (DATA_WIDTH),
        .MENT_WIDTH (MENT_WIDTH),
        .EXPO_WIDTH (EXPO_WIDTH)
    ) u_round_pack (
        .sign   (sign_q),
        .expo   (exp_q),
        .mant   (big_q[WM-2:0]),
        .result (rp_result),
        .flags  (rp_flags)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (in_valid_in) state_next = UNPACK;
            UNPACK: if (is_special)       state_next = ROUND;
                    else if (diff == '0)  state_next = ADD;
                    else                  state_next = ALIGN;
            ALIGN:  if (cnt_q > ALIGN_LIMIT || cnt_q == EXPO_WIDTH'(1)) state_next = ADD;
            ADD:    if (sum_zero)                         state_next = DONE;
                    else if (sum_w[WM-1] || !sum_w[WM-2]) state_next = NORM;
                    else                                  state_next = ROUND;
            NORM:   if (big_q[WM-1])            state_next = ROUND;
                    else if (exp_q == EXP_MIN)  state_next = DONE;
                    else if (norm_left[WM-2])   state_next = ROUND;
            ROUND:  state_next = DONE;
            DONE:   if (out_ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_out  = (state == IDLE);
        out_valid_out = (state == DONE);
        busy_out      = (state != IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                UNPACK: if (is_special) begin
                    result_q <= spec_res;
                    flags_q  <= spec_flags;
                end
                ADD: if (sum_zero) begin
                    result_q <= '0;
                    flags_q  <= '0;
                end
                NORM: if (!big_q[WM-1] && exp_q == EXP_MIN) begin
                    result_q                 <= {sign_q, {(DATA_WIDTH-1){1'b0}}};
                    flags_q                  <= '0;
                    flags_q[FLAG_UNDERFLOW]  <= 1'b1;
                    flags_q[FLAG_INEXACT]    <= 1'b1;
                end
                ROUND: if (!special_q) begin
                    result_q <= rp_result;
                    flags_q  <= rp_flags;
                end
                default: ;
            endcase
        end
    end

    // NOTE: working registers carry no reset; each is loaded before any state that reads it.
    always_ff @(posedge clk_in) begin
        case (state)
            IDLE: if (in_valid_in) begin
                a_q  <= floating1_in;
                b_q  <= floating2_in;
                op_q <= opcode_in;
            end
            UNPACK: begin
                special_q <= is_special;
                sub_q     <= sign_a ^ sign_b;
                sign_q    <= a_big ? sign_a : sign_b;
                exp_q     <= {2'b00, a_big ? exp_a : exp_b};
                big_q     <= a_big ? man_a : man_b;
                small_q   <= a_big ? man_b : man_a;
                cnt_q     <= diff;
            end
            ALIGN: begin
                if (cnt_q > ALIGN_LIMIT) small_q <= WM'(1);
                else small_q <= {1'b0, small_q[WM-1:2], small_q[1] | small_q[0]};
                cnt_q <= cnt_q - EXPO_WIDTH'(1);
            end
            ADD: big_q <= sum_w;
            NORM: if (big_q[WM-1]) begin
                big_q <= norm_right;
                exp_q <= exp_q + EI'(1);
            end else begin
                big_q <= norm_left;
                exp_q <= exp_q - EI'(1);
            end
            default: ;
        endcase
    end

    assign floating_addition_out = result_q;
    assign flags_out             = flags_q;

endmodule
